// File: rtl/fifo_demux_1_2_pkg.sv
// Shared sizing helpers for the 1-to-2 FIFO demultiplexer.
package fifo_demux_1_2_pkg;

    // Pointer width for a power-of-two depth (at least one bit).
    function automatic int unsigned ptr_w(input int unsigned d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

    // Occupancy count needs one extra bit so that "depth" itself is representable.
    function automatic int unsigned cnt_w(input int unsigned d);
        return ptr_w(d) + 1;
    endfunction

endpackage

// File: rtl/fifo_demux_1_2_chan.sv
// Single-channel first-word-fall-through FIFO with a zero-masked head word.
module fifo_chan
    import fifo_demux_1_2_pkg::*;
#(
    parameter int unsigned bw    = 8,
    parameter int unsigned depth = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [bw-1:0] wdata,
    input  logic          pop,
    output logic [bw-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int unsigned PW = ptr_w(depth);
    localparam int unsigned CW = cnt_w(depth);
    localparam logic [CW-1:0] FULL_CNT = CW'(depth);

    logic [bw-1:0] mem [depth];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    // Requests are qualified locally so count can neither overflow nor underflow.
    always_comb begin
        do_push = push & ~full;
        do_pop  = pop & ~empty;
    end

    // Storage is never cleared; stale words are hidden by the empty mask.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fifo_demux_1_2.sv
// Steers one input stream into two independent FWFT channel FIFOs by in_sel.
module fifo_demux_1_2
    import fifo_demux_1_2_pkg::*;
#(
    parameter int unsigned bw    = 8,
    parameter int unsigned depth = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic          in_sel,
    input  logic [bw-1:0] in_data,
    output logic          in_ready,
    output logic          out0_valid,
    input  logic          out0_ready,
    output logic [bw-1:0] out0_data,
    output logic          out1_valid,
    input  logic          out1_ready,
    output logic [bw-1:0] out1_data,
    output logic          full0,
    output logic          full1,
    output logic          empty0,
    output logic          empty1
);

    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    full;
    logic [1:0]    empty;
    logic [1:0]    ready;
    logic [bw-1:0] rdata [2];

    // Acceptance depends only on the selected channel's registered fullness.
    always_comb begin
        ready    = {out1_ready, out0_ready};
        in_ready = ~full[in_sel];
    end

    for (genvar k = 0; k < 2; k++) begin : g_chan
        // Per-channel push/pop decode: only the selected channel is written.
        always_comb begin
            push[k] = in_valid & in_ready & (in_sel == 1'(k));
            pop[k]  = ready[k] & ~empty[k];
        end

        fifo_chan #(
            .bw    (bw),
            .depth (depth)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .push  (push[k]),
            .wdata (in_data),
            .pop   (pop[k]),
            .rdata (rdata[k]),
            .full  (full[k]),
            .empty (empty[k])
        );
    end

    assign out0_valid = ~empty[0];
    assign out1_valid = ~empty[1];
    assign out0_data  = rdata[0];
    assign out1_data  = rdata[1];
    assign full0      = full[0];
    assign full1      = full[1];
    assign empty0     = empty[0];
    assign empty1     = empty[1];

endmodule

// File: tb/tb_fifo_demux_1_2.sv
// Directed self-checking bench for fifo_demux_1_2 (bw=8, depth=4).
module tb_fifo_demux_1_2;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_sel;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out0_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] out1_data;
    logic       full0;
    logic       full1;
    logic       empty0;
    logic       empty1;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    fifo_demux_1_2 #(
        .bw    (8),
        .depth (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .full0      (full0),
        .full1      (full1),
        .empty0     (empty0),
        .empty1     (empty1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic sel, input logic [7:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop0();
        out0_ready = 1'b1;
        tick();
        out0_ready = 1'b0;
    endtask

    task automatic pop1();
        out1_ready = 1'b1;
        tick();
        out1_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_head;

        reset      = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 8'hEE;
        out0_ready = 1'b0;
        out1_ready = 1'b0;

        // Reset held 2 cycles with in_valid high: nothing may be stored.
        tick();
        tick();
        reset    = 1'b1;
        in_valid = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_v0", out0_valid, 0);
        chk("rst_v1", out1_valid, 0);
        chk("rst_d0", out0_data, 0);
        chk("rst_d1", out1_data, 0);
        chk("rst_full0", full0, 0);
        chk("rst_full1", full1, 0);
        chk("rst_empty0", empty0, 1);
        chk("rst_empty1", empty1, 1);

        // Alternating pushes with both readies low.
        push(1'b0, 8'h11);
        chk("lat_v0", out0_valid, 1);
        chk("lat_d0", out0_data, 8'h11);
        chk("lat_v1_untouched", out1_valid, 0);
        push(1'b1, 8'h22);
        push(1'b0, 8'h33);
        chk("alt_d0", out0_data, 8'h11);
        chk("alt_d1", out1_data, 8'h22);
        pop0();
        chk("alt_pop_d0", out0_data, 8'h33);
        chk("alt_pop_d1", out1_data, 8'h22);

        // Drain channel 0, then fill it to depth.
        pop0();
        chk("drained_empty0", empty0, 1);
        push(1'b0, 8'hA0);
        push(1'b0, 8'hA1);
        push(1'b0, 8'hA2);
        chk("fill3_full0", full0, 0);
        push(1'b0, 8'hA3);
        chk("fill_full0", full0, 1);
        chk("fill_empty0", empty0, 0);
        chk("fill_head0", out0_data, 8'hA0);
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 8'h55;
        #1;
        chk("full_in_ready_sel0", in_ready, 0);
        in_sel = 1'b1;
        #1;
        chk("full_in_ready_sel1", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("redirect_head0", out0_data, 8'hA0);
        chk("redirect_full0", full0, 1);
        chk("redirect_head1", out1_data, 8'h22);
        pop1();
        chk("redirect_landed1", out1_data, 8'h55);
        pop1();
        chk("ch1_empty", empty1, 1);

        // Bring channel 0 to count 2, then 8 cycles of push+pop.
        pop0();
        pop0();
        chk("cnt2_head", out0_data, 8'hA2);
        for (int i = 0; i < 8; i++) begin
            exp_head   = (i == 0) ? 8'hA2 : (i == 1) ? 8'hA3 : 8'(8'hB0 + i - 2);
            in_valid   = 1'b1;
            in_sel     = 1'b0;
            in_data    = 8'(8'hB0 + i);
            out0_ready = 1'b1;
            #1;
            chk($sformatf("pp_head_%0d", i), out0_data, exp_head);
            chk($sformatf("pp_in_ready_%0d", i), in_ready, 1);
            tick();
        end
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        chk("pp_after_head", out0_data, 8'hB6);
        chk("pp_after_full0", full0, 0);
        pop0();
        chk("pp_last_head", out0_data, 8'hB7);

        // Empty drain and ignored extra pops.
        pop0();
        chk("drain_v0", out0_valid, 0);
        chk("drain_d0", out0_data, 0);
        chk("drain_empty0", empty0, 1);
        out0_ready = 1'b1;
        tick();
        tick();
        out0_ready = 1'b0;
        chk("underflow_empty0", empty0, 1);
        push(1'b0, 8'h77);
        chk("after_underflow_head", out0_data, 8'h77);
        pop0();
        chk("after_underflow_empty0", empty0, 1);

        // Reset mid-traffic.
        push(1'b0, 8'hC1);
        push(1'b0, 8'hC2);
        push(1'b0, 8'hC3);
        push(1'b1, 8'hD1);
        push(1'b1, 8'hD2);
        chk("pre_rst_d0", out0_data, 8'hC1);
        chk("pre_rst_d1", out1_data, 8'hD1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid_rst_empty0", empty0, 1);
        chk("mid_rst_empty1", empty1, 1);
        chk("mid_rst_d0", out0_data, 0);
        chk("mid_rst_d1", out1_data, 0);
        chk("mid_rst_v1", out1_valid, 0);
        push(1'b1, 8'hAB);
        chk("post_rst_v1", out1_valid, 1);
        chk("post_rst_d1", out1_data, 8'hAB);
        chk("post_rst_empty0", empty0, 1);
        pop1();
        chk("post_rst_single", empty1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
